// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: holds HI/LO and runs mult/div as fixed-latency
// operations. The result is computed at accept time and committed when the countdown expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUop,
  output logic        start,
  output logic        busy,
  output logic [31:0] MDUres
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
                         OP_DIVU  = 4'd4, OP_MFHI  = 4'd5, OP_MFLO = 4'd6,
                         OP_MTHI  = 4'd7, OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
  logic           commit_q, commit_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, den_s, den_u, sq_mag, sr_mag, q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  // A zero divisor is forced to 1 only to keep the datapath defined; that result is never committed.
  assign a_mag  = A[31] ? (32'd0 - A) : A;
  assign b_mag  = B[31] ? (32'd0 - B) : B;
  assign den_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign den_u  = (B == 32'd0) ? 32'd1 : B;
  assign sq_mag = a_mag / den_s;
  assign sr_mag = a_mag % den_s;
  assign q_s    = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign r_s    = A[31] ? (32'd0 - sr_mag) : sr_mag;
  assign q_u    = A / den_u;
  assign r_u    = A % den_u;

  assign busy = (state_q == BUSY);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    thi_d    = thi_q;
    tlo_d    = tlo_q;
    commit_d = commit_q;
    start    = 1'b0;
    MDUres   = 32'd0;

    case (MDUop)
      OP_MFHI: MDUres = hi_q;
      OP_MFLO: MDUres = lo_q;
      default: MDUres = 32'd0;
    endcase

    case (state_q)
      IDLE: begin
        case (MDUop)
          OP_MULT, OP_MULTU: begin
            start    = 1'b1;
            state_d  = BUSY;
            cnt_d    = CW'(MULT_CYCLES);
            commit_d = 1'b1;
            {thi_d, tlo_d} = (MDUop == OP_MULT) ? 64'(prod_s) : prod_u;
          end
          OP_DIV, OP_DIVU: begin
            start    = 1'b1;
            state_d  = BUSY;
            cnt_d    = CW'(DIV_CYCLES);
            commit_d = (B != 32'd0);
            thi_d    = (MDUop == OP_DIV) ? r_s : r_u;
            tlo_d    = (MDUop == OP_DIV) ? q_s : q_u;
          end
          OP_MTHI: hi_d = A;
          OP_MTLO: lo_d = A;
          default: ;
        endcase
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (commit_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      thi_q    <= 32'd0;
      tlo_q    <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      thi_q    <= thi_d;
      tlo_q    <= tlo_d;
      commit_q <= commit_d;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUop;
  logic        start, busy;
  logic [31:0] MDUres;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop),
    .start(start), .busy(busy), .MDUres(MDUres)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 MDUres, 1 busy, 2 start
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = MDUres;
        1:       act = {31'd0, busy};
        default: act = {31'd0, start};
      endcase
      n_chk++;
      if (e.cyc != cyc_cnt || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", e.name, cyc_cnt, act, e.exp);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    MDUop = op; A = a; B = b;
  endtask

  task automatic expect_v(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc_cnt; e.kind = kind; e.exp = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic read_hilo(input logic [31:0] hi, input logic [31:0] lo, input string tag);
    drive(4'd5, 32'd0, 32'd0);
    expect_v(0, hi, {tag, "_hi"});
    expect_v(1, 32'd0, {tag, "_idle"});
    drive(4'd6, 32'd0, 32'd0);
    expect_v(0, lo, {tag, "_lo"});
  endtask

  // Issue an op, check busy for exactly n cycles, then read HI/LO in cycle n+1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] hi, input logic [31:0] lo, input string tag);
    drive(op, a, b);
    expect_v(2, 32'd1, {tag, "_start"});
    expect_v(1, 32'd0, {tag, "_busy0"});
    for (int i = 1; i <= n; i++) begin
      drive(4'd0, 32'd0, 32'd0);
      expect_v(1, 32'd1, {tag, "_busy"});
    end
    read_hilo(hi, lo, tag);
  endtask

  initial begin
    reset = 1'b1; MDUop = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    read_hilo(32'd0, 32'd0, "reset");

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, "multu");
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    run_op(4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");

    drive(4'd7, 32'h12345678, 32'd0);
    expect_v(2, 32'd0, "mthi_start");
    expect_v(1, 32'd0, "mthi_busy");
    run_op(4'd3, 32'd5, 32'd0, 10, 32'h12345678, 32'd3, "div0");
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, "divovf");

    drive(4'd9, 32'hFFFFFFFF, 32'd1);
    expect_v(2, 32'd0, "unused_start");
    expect_v(0, 32'd0, "unused_res");

    // mtlo issued mid-operation must be dropped
    drive(4'd1, 32'd3, 32'd4);
    expect_v(2, 32'd1, "mtlo_mid_start");
    drive(4'd0, 32'd0, 32'd0);
    expect_v(1, 32'd1, "mtlo_mid_busy1");
    drive(4'd8, 32'h0000DEAD, 32'd0);
    expect_v(2, 32'd0, "mtlo_mid_nostart");
    expect_v(1, 32'd1, "mtlo_mid_busy2");
    for (int i = 3; i <= 5; i++) begin
      drive(4'd0, 32'd0, 32'd0);
      expect_v(1, 32'd1, "mtlo_mid_busy");
    end
    read_hilo(32'd0, 32'd12, "mtlo_mid");

    // reset mid-operation discards the pending product
    drive(4'd7, 32'h00000055, 32'd0);
    drive(4'd1, 32'd3, 32'd4);
    expect_v(2, 32'd1, "rst_mid_start");
    drive(4'd0, 32'd0, 32'd0);
    drive(4'd0, 32'd0, 32'd0);
    drive(4'd0, 32'd0, 32'd0);
    expect_v(1, 32'd1, "rst_mid_busy3");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_v(1, 32'd0, "rst_mid_busy_clr");
    read_hilo(32'd0, 32'd0, "rst_mid");
    for (int i = 0; i < 5; i++) begin
      drive(4'd6, 32'd0, 32'd0);
      expect_v(0, 32'd0, "rst_mid_nolate");
      expect_v(1, 32'd0, "rst_mid_idle");
    end

    drive(4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage, alongside the single-cycle ALU.
- Takes the same A/B operands and holds architectural HI/LO registers.
- Serves mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Exposes start/busy so hazard logic stalls D-stage MDU instructions while an operation is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  32  rs operand.
- B  input  32  rt operand.
- MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others behave as 0.
- start  output  1  combinational; 1 when MDUop is 1..4 and unit is IDLE.
- busy  output  1  registered; 1 while an operation is in flight.
- MDUres  output  32  combinational read data: HI for op 5, LO for op 6, else 0.

Behaviour:
- Clock and reset
  - Single clock.
  - Reset is synchronous, active-high: on a clk edge with reset=1, HI=0, LO=0, busy=0, counter=0, state=IDLE.
  - Reset wins over every other event, including mid-operation; the pending result is discarded.
- States
  - IDLE: busy=0.
  - BUSY: busy=1, counter counts down.
- Accepting an operation (IDLE, MDUop 1..4)
  - On the edge, latch the full result into temp_hi/temp_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy=1 from the next cycle.
- BUSY
  - Each edge decrements the counter.
  - On the edge where counter==1: HI<=temp_hi, LO<=temp_lo, busy<=0, go to IDLE.
  - Net timing: start in cycle 0; busy high for exactly N cycles (1..N); new HI/LO readable in cycle N+1.
- Ops while BUSY
  - Any MDUop is ignored and start=0.
  - Hazard unit guarantees no MDU instruction enters E while start|busy; the unit does not queue.
- mthi/mtlo
  - IDLE only: HI<=A or LO<=A at the edge; 1-cycle effect, busy stays 0.
- mfhi/mflo
  - MDUres combinational from current HI/LO.
  - Same-cycle write by mthi/mtlo is not forwarded.
- Arithmetic
  - mult: {HI,LO} = signed 64-bit A*B.
  - multu: {HI,LO} = unsigned 64-bit A*B.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of A (signed).
  - divu: LO = A/B, HI = A%B (unsigned).
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero: operation runs its full DIV_CYCLES with busy as normal, but HI/LO keep their prior values at completion.
- Unused MDUop codes: no state change, start=0, MDUres=0.

Test Plan:
- Reset, then mfhi and mflo -> MDUres=0 for both; busy=0.
- mult A=0xFFFFFFFE (-2), B=3, then poll -> busy high for exactly 5 cycles; in cycle 6 mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA.
  - Same operands via multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then div A=5, B=0 -> busy 10 cycles; afterwards HI=0x12345678, LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult 3*4; at busy cycle 2 drive MDUop=mtlo, A=0xDEAD -> mtlo ignored, start=0; after completion LO=12, HI=0.
- mult 3*4; assert reset at busy cycle 3 -> next cycle busy=0, HI=LO=0; no late commit of 12 afterwards.
